load_store_unit: RTL and testbench

Request/response front end for the CPU's data-side memory traffic. Accepts one 16-bit word load or store at a time from the execute stage over a valid/ready handshake. Routes each access either to port A of the data memory or to a memory-mapped I/O window. Returns a registered response held until the consumer accepts it. Sits directly upstream of the data memory and absorbs that memory's one-cycle synchronous read latency so the core does not have to.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/load_store_unit_if.sv | 44 ++++
 rtl/mem_io_decode.sv | 16 +
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-side memory path: word width, the default
// I/O window selector and the load/store unit state encoding.
package cpu_mem_pkg;

    localparam int WORD_W = 16;
    localparam logic [7:0] IO_BASE_HI_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the data-memory and I/O port signals of the
// load/store unit. The slave modport is the unit's view; master is its environment.
interface load_store_unit_if;
    import cpu_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_address;
    logic [WORD_W-1:0] req_write_data;

    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_read_data;
    logic              resp_was_write;

    logic [WORD_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [WORD_W-1:0] mem_read_data;

    logic [7:0]        io_address;
    logic [WORD_W-1:0] io_write_data;
    logic              io_write_enable;
    logic              io_read_enable;
    logic [WORD_W-1:0] io_read_data;

    modport slave (
        input  req_valid, req_write, req_address, req_write_data,
        input  resp_ready, mem_read_data, io_read_data,
        output req_ready, resp_valid, resp_read_data, resp_was_write,
        output mem_address, mem_write_data, mem_write_enable,
        output io_address, io_write_data, io_write_enable, io_read_enable
    );

    modport master (
        output req_valid, req_write, req_address, req_write_data,
        output resp_ready, mem_read_data, io_read_data,
        input  req_ready, resp_valid, resp_read_data, resp_was_write,
        input  mem_address, mem_write_data, mem_write_enable,
        input  io_address, io_write_data, io_write_enable, io_read_enable
    );

endinterface

// File: rtl/mem_io_decode.sv
// Combinational address-to-target decode: any address whose upper byte equals
// IO_BASE_HI falls in the I/O window. Shared with the instruction-fetch side.
module mem_io_decode
    import cpu_mem_pkg::*;
#(
    parameter logic [7:0] IO_BASE_HI = IO_BASE_HI_DEFAULT
) (
    input  logic [WORD_W-1:0] address,
    output logic              is_io,
    output logic [7:0]        io_address
);

    assign is_io      = (address[15:8] == IO_BASE_HI);
    assign io_address = address[7:0];

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store front end: routes one access to data memory or the
// I/O window and holds a registered response, absorbing the one-cycle read latency.
module load_store_unit
    import cpu_mem_pkg::*;
#(
    parameter logic [7:0] IO_BASE_HI = IO_BASE_HI_DEFAULT
) (
    input logic              clock,
    input logic              reset_n,
    load_store_unit_if.slave bus
);

    lsu_state_t        state;
    lsu_state_t        state_next;
    logic              req_write_q;
    logic              req_is_io_q;
    logic [WORD_W-1:0] req_write_data_q;
    logic [WORD_W-1:0] resp_data_q;
    logic              resp_was_write_q;
    logic              dec_is_io;
    logic [7:0]        dec_io_address;

    mem_io_decode #(
        .IO_BASE_HI (IO_BASE_HI)
    ) u_decode (
        .address    (bus.req_address),
        .is_io      (dec_is_io),
        .io_address (dec_io_address)
    );

    assign bus.resp_read_data = resp_data_q;
    assign bus.resp_was_write = resp_was_write_q;

    always_comb begin
        state_next           = state;
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.io_write_enable  = 1'b0;
        bus.io_read_enable   = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = ACCESS;
            end
            ACCESS: begin
                bus.mem_write_enable = req_write_q & ~req_is_io_q;
                bus.io_write_enable  = req_write_q & req_is_io_q;
                bus.io_read_enable   = ~req_write_q & req_is_io_q;
                state_next           = req_write_q ? RESPOND : WAIT;
            end
            WAIT: state_next = RESPOND;
            RESPOND: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/data registers double as the port drivers, so they hold between accesses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            req_write_q        <= 1'b0;
            req_is_io_q        <= 1'b0;
            req_write_data_q   <= '0;
            resp_data_q        <= '0;
            resp_was_write_q   <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.io_address     <= '0;
            bus.io_write_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_write_q      <= bus.req_write;
                        req_is_io_q      <= dec_is_io;
                        req_write_data_q <= bus.req_write_data;
                        if (dec_is_io) begin
                            bus.io_address    <= dec_io_address;
                            bus.io_write_data <= bus.req_write_data;
                        end else begin
                            bus.mem_address    <= bus.req_address;
                            bus.mem_write_data <= bus.req_write_data;
                        end
                    end
                end
                ACCESS: begin
                    if (req_write_q) begin
                        resp_data_q      <= req_write_data_q;
                        resp_was_write_q <= 1'b1;
                    end
                end
                WAIT: begin
                    resp_data_q      <= req_is_io_q ? bus.io_read_data : bus.mem_read_data;
                    resp_was_write_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered memory and I/O device model.
module tb_load_store_unit;

    localparam int BUDGET = 20;

    typedef struct {
        logic [15:0] data;
        logic        was_write;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    load_store_unit_if bus ();

    load_store_unit #(.IO_BASE_HI(8'hFF)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:65535];
    logic [15:0] io_value;
    logic [15:0] io_last_write;
    logic [15:0] shadow [logic [15:0]];
    exp_t        sb [$];
    int          mem_we_cnt, io_we_cnt, io_re_cnt;

    always @(posedge clock) begin
        if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
        bus.mem_read_data <= mem[bus.mem_address];
        if (bus.io_read_enable) bus.io_read_data <= io_value;
        if (bus.io_write_enable) io_last_write <= bus.io_write_data;
    end

    always @(negedge clock) begin
        if (bus.mem_write_enable === 1'b1) mem_we_cnt++;
        if (bus.io_write_enable === 1'b1) io_we_cnt++;
        if (bus.io_read_enable === 1'b1) io_re_cnt++;
    end

    function automatic exp_t model(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        if (wr) begin
            e.data = wdata;
            e.was_write = 1'b1;
        end else if (addr[15:8] == 8'hFF) begin
            e.data = io_value;
            e.was_write = 1'b0;
        end else begin
            e.data = shadow.exists(addr) ? shadow[addr] : 16'h0000;
            e.was_write = 1'b0;
        end
        return e;
    endfunction

    // lat counts sampling points after the accept edge, the first one included.
    task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       output int lat, output logic [15:0] rdata, output logic rww, output logic tmo);
        int n;
        tmo = 1'b0; lat = 0; rdata = '0; rww = 1'b0;
        @(negedge clock);
        mem_we_cnt = 0; io_we_cnt = 0; io_re_cnt = 0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_address = addr;
        bus.req_write_data = wdata; bus.resp_ready = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BUDGET) begin @(negedge clock); n++; end
        if (bus.req_ready !== 1'b1) begin tmo = 1'b1; bus.req_valid = 1'b0; return; end
        @(posedge clock);
        sb.push_back(model(wr, addr, wdata));
        if (wr && addr[15:8] != 8'hFF) shadow[addr] = wdata;
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < BUDGET) begin @(negedge clock); lat++; end
        if (bus.resp_valid !== 1'b1) begin tmo = 1'b1; void'(sb.pop_back()); return; end
        rdata = bus.resp_read_data;
        rww = bus.resp_was_write;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_address = '0;
        bus.req_write_data = '0; bus.resp_ready = 1'b0; io_value = '0;
        repeat (3) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
        checks++; if (bus.resp_read_data !== 16'h0) begin errors++; $display("FAIL reset_resp_data got=%h want=0000", bus.resp_read_data); end
        checks++; if (bus.resp_was_write !== 1'b0) begin errors++; $display("FAIL reset_was_write got=%b want=0", bus.resp_was_write); end
        checks++; if ({bus.mem_address, bus.mem_write_data} !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h want=0000/0000", bus.mem_address, bus.mem_write_data); end
        checks++; if ({bus.io_address, bus.io_write_data} !== 24'h0) begin errors++; $display("FAIL reset_io_bus got=%h/%h want=00/0000", bus.io_address, bus.io_write_data); end
        checks++; if ({bus.mem_write_enable, bus.io_write_enable, bus.io_read_enable} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes got=%b%b%b want=000", bus.mem_write_enable, bus.io_write_enable, bus.io_read_enable);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_store_load;
        int lat; logic [15:0] rd; logic rww, tmo; exp_t e;
        txn(1'b1, 16'h0010, 16'hBEEF, lat, rd, rww, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL store_timeout got=timeout want=response"); end
        else begin
            e = sb.pop_front();
            if (lat !== 2) begin errors++; $display("FAIL store_latency got=%0d want=2", lat); end
            checks++; if (rd !== e.data || rww !== e.was_write) begin errors++; $display("FAIL store_resp got=%h/%b want=%h/%b", rd, rww, e.data, e.was_write); end
            checks++; if (mem_we_cnt !== 1 || io_we_cnt !== 0) begin errors++; $display("FAIL store_strobes got mem_we=%0d io_we=%0d want 1/0", mem_we_cnt, io_we_cnt); end
            checks++; if (bus.mem_address !== 16'h0010) begin errors++; $display("FAIL store_mem_address got=%h want=0010", bus.mem_address); end
        end
        txn(1'b0, 16'h0010, 16'h0000, lat, rd, rww, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL load_timeout got=timeout want=response"); end
        else begin
            e = sb.pop_front();
            if (lat !== 3) begin errors++; $display("FAIL load_latency got=%0d want=3", lat); end
            checks++; if (rd !== e.data || rww !== e.was_write) begin errors++; $display("FAIL load_resp got=%h/%b want=%h/%b", rd, rww, e.data, e.was_write); end
            checks++; if (mem_we_cnt !== 0 || io_re_cnt !== 0) begin errors++; $display("FAIL load_strobes got mem_we=%0d io_re=%0d want 0/0", mem_we_cnt, io_re_cnt); end
        end
    endtask

    task automatic test_io_decode;
        int lat; logic [15:0] rd; logic rww, tmo; exp_t e;
        txn(1'b1, 16'hFF05, 16'h1234, lat, rd, rww, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL io_store_timeout got=timeout want=response"); end
        else begin
            e = sb.pop_front();
            if (rd !== e.data || lat !== 2) begin errors++; $display("FAIL io_store_resp got=%h lat=%0d want=%h lat=2", rd, lat, e.data); end
            checks++; if (io_we_cnt !== 1 || mem_we_cnt !== 0) begin errors++; $display("FAIL io_store_strobes got io_we=%0d mem_we=%0d want 1/0", io_we_cnt, mem_we_cnt); end
            checks++; if (bus.io_address !== 8'h05 || io_last_write !== 16'h1234) begin
                errors++; $display("FAIL io_store_target got addr=%h data=%h want 05/1234", bus.io_address, io_last_write);
            end
        end
        txn(1'b1, 16'hFEFF, 16'h7777, lat, rd, rww, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL feff_timeout got=timeout want=response"); end
        else begin
            e = sb.pop_front();
            if (mem_we_cnt !== 1 || io_we_cnt !== 0) begin errors++; $display("FAIL feff_strobes got mem_we=%0d io_we=%0d want 1/0", mem_we_cnt, io_we_cnt); end
            checks++; if (rd !== e.data || bus.mem_address !== 16'hFEFF) begin errors++; $display("FAIL feff_resp got=%h addr=%h want=%h addr=feff", rd, bus.mem_address, e.data); end
        end
    endtask

    task automatic test_backpressure;
        int lat, n; logic [15:0] rd, held; logic rww, tmo, bad; exp_t e;
        txn(1'b1, 16'h0020, 16'hC0DE, lat, rd, rww, tmo);
        if (!tmo) void'(sb.pop_front());
        @(negedge clock);
        bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0020;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BUDGET) begin @(negedge clock); n++; end
        @(posedge clock);
        sb.push_back(model(1'b0, 16'h0020, 16'h0000));
        @(negedge clock);
        bus.req_write = 1'b1; bus.req_address = 16'h0030; bus.req_write_data = 16'h5555;
        bad = 1'b0; n = 0;
        while (bus.resp_valid !== 1'b1 && n < BUDGET) begin
            if (bus.req_ready !== 1'b0) bad = 1'b1;
            @(negedge clock); n++;
        end
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_timeout got=timeout want=response");
            bus.req_valid = 1'b0; bus.resp_ready = 1'b1; void'(sb.pop_front());
            return;
        end
        held = bus.resp_read_data;
        e = sb.pop_front();
        if (held !== e.data || bad) begin errors++; $display("FAIL bp_load_resp got=%h busy_ready_bad=%b want=%h 0", held, bad, e.data); end
        repeat (5) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b1 || bus.resp_read_data !== held || bus.req_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_hold got=unstable want=stable valid/data, ready=0"); end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.resp_valid);
        end
        sb.push_back(model(1'b1, 16'h0030, 16'h5555));
        shadow[16'h0030] = 16'h5555;
        @(negedge clock);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got ready=%b want=0", bus.req_ready); end
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < BUDGET) begin @(negedge clock); n++; end
        e = sb.pop_front();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_read_data !== e.data || bus.resp_was_write !== e.was_write) begin
            errors++; $display("FAIL bp_second_resp got=%h/%b valid=%b want=%h/%b", bus.resp_read_data, bus.resp_was_write, bus.resp_valid, e.data, e.was_write);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_load;
        int lat, n; logic [15:0] rd; logic rww, tmo, rose; exp_t e;
        txn(1'b1, 16'h0040, 16'h4242, lat, rd, rww, tmo);
        if (!tmo) void'(sb.pop_front());
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0040; bus.resp_ready = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BUDGET) begin @(negedge clock); n++; end
        @(posedge clock);
        sb.push_back(model(1'b0, 16'h0040, 16'h0000));
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_idle got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
        end
        rose = 1'b0;
        repeat (3) begin @(negedge clock); if (bus.resp_valid !== 1'b0) rose = 1'b1; end
        reset_n = 1'b1;
        repeat (2) begin @(negedge clock); if (bus.resp_valid !== 1'b0) rose = 1'b1; end
        checks++; if (rose !== 1'b0) begin errors++; $display("FAIL rst_mid_discard got resp_valid=1 want=0"); end
        txn(1'b0, 16'h0040, 16'h0000, lat, rd, rww, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL rst_reload_timeout got=timeout want=response"); end
        else begin
            e = sb.pop_front();
            if (rd !== e.data || rww !== 1'b0 || lat !== 3) begin errors++; $display("FAIL rst_reload got=%h/%b lat=%0d want=%h/0 lat=3", rd, rww, lat, e.data); end
        end
    endtask

    task automatic test_boundary;
        int lat; logic [15:0] rd; logic rww, tmo; exp_t e;
        io_value = 16'hA5A5;
        txn(1'b0, 16'hFFFF, 16'h0000, lat, rd, rww, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL ffff_timeout got=timeout want=response"); end
        else begin
            e = sb.pop_front();
            if (rd !== e.data || rww !== 1'b0 || lat !== 3) begin errors++; $display("FAIL ffff_resp got=%h/%b lat=%0d want=%h/0 lat=3", rd, rww, lat, e.data); end
            checks++; if (io_re_cnt !== 1 || mem_we_cnt !== 0 || bus.io_address !== 8'hFF) begin
                errors++; $display("FAIL ffff_strobes got io_re=%0d mem_we=%0d addr=%h want 1/0/ff", io_re_cnt, mem_we_cnt, bus.io_address);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_io_decode();
        test_backpressure();
        test_reset_mid_load();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
